btn_event_sched: RTL and testbench
==================================

# btn_event_sched

Shared-timebase debounce and event scheduler for the board push-buttons. It samples `N_BTN` raw inputs on one common divided tick and filters each to a stable level. It turns level edges into pending events and hands them one at a time, round-robin, to a single consumer (FSM or display logic) over a valid/ready handshake. It replaces per-button divider chains with one counter and one arbiter.

## Interface
- `N_BTN`, 4: number of buttons, 2..16.
- `TICK_DIV`, 100000: sample-tick period in `clk` cycles (1 ms at 100 MHz), ≥2.
- `STABLE_CNT`, 4: consecutive differing samples needed to accept a new level, ≥1.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_in`  in  N_BTN  raw, asynchronous button inputs, active-high.
- `tick`  out  1  one-cycle sample strobe, exported for sharing.
- `btn_level`  out  N_BTN  debounced levels.
- `evt_valid`  out  1  event offered.
- `evt_id`  out  $clog2(N_BTN)  button index of offered event.
- `evt_press`  out  1  1 = press, 0 = release.
- `evt_ready`  in  1  consumer accepts the event when high with `evt_valid`.
- `evt_ovf`  out  1  sticky; set when an edge hits an already-pending bit.

## Operation
- Tick counter: counts 0..TICK_DIV-1 and wraps to 0. `tick` is high exactly in the cycle the counter equals TICK_DIV-1.
- Sync: each `btn_in` bit passes through 2 flops every `clk`, giving `sync[i]`.
- Filter per button, evaluated only when `tick` is high:
  - `sync[i]` == `btn_level[i]`: clear `cnt[i]`.
  - Otherwise, if `cnt[i]` == STABLE_CNT-1: toggle `btn_level[i]` and clear `cnt[i]`.
  - Otherwise: increment `cnt[i]`.
  - A single opposing sample restarts the count.
- Edge detect: `lvl_q` is `btn_level` registered.
  - Rising edge (`btn_level`=1, `lvl_q`=0) sets `press_pend[i]`.
  - Falling edge sets `rel_pend[i]` (macro only).
- Pending bits:
  - A set on a bit that is already 1 leaves it at 1 and sets `evt_ovf`.
  - Set and clear on the same bit in the same cycle: set wins; `evt_ovf` is not raised.
- Arbiter FSM:
  - IDLE: if any pending bit is set, select the first index at or after `rr_ptr`, wrapping, that has a pending bit. Press outranks release for the same index. Register `evt_id` and `evt_press`, drive `evt_valid`=1, go to OFFER. Otherwise stay in IDLE.
  - OFFER: `evt_id` and `evt_press` hold stable. When `evt_valid`&&`evt_ready`: clear the chosen pending bit, set `rr_ptr` = (`evt_id`+1) mod N_BTN, drop `evt_valid`, return to IDLE.
- `evt_ovf` clears only on reset.
- Reset values:
  - Outputs: `tick`, `btn_level`, `evt_valid`, `evt_id`, `evt_press`, `evt_ovf` all 0.
  - Internal state: counters, sync flops, `lvl_q`, pending bits and `rr_ptr` all 0; FSM in IDLE.
  - Buttons already held at reset release produce a press event after filtering.

## Timing
- Raw change to `sync`: 2 cycles.
- `sync` change to `btn_level` toggle: at the STABLE_CNT-th `tick` seen with the new value.
- `btn_level` toggle (cycle T) to pending bit set: T+1.
- `evt_valid` high: T+2 if the FSM is in IDLE, otherwise 1 cycle after the current handshake completes.
- Throughput: at most one event every 2 cycles; `evt_valid` is low for at least 1 cycle between events.
- `evt_ready` may be high before `evt_valid`; the handshake occurs in the first cycle both are high.
- Reset asserted mid-offer: `evt_valid` drops immediately (asynchronous); all pending events are lost.

## Configuration
- `BTN_RELEASE_EVT_EN` defined: falling edges set `rel_pend`, and release events are offered with `evt_press`=0.
- `BTN_RELEASE_EVT_EN` undefined:
  - `rel_pend` logic is absent and releases generate no events.
  - `evt_press` is tied to 1.
  - Overflow can only come from presses.

## Test plan
- Reset with `btn_in`=0, N_BTN=4, TICK_DIV=8, STABLE_CNT=3 -> all outputs 0; `tick` pulses every 8 cycles.
- `btn_in[2]` rises and holds -> `btn_level[2]`=1 at the 3rd tick after sync; `evt_valid`=1 two cycles later with `evt_id`=2, `evt_press`=1; `evt_ready`=1 clears it.
- `btn_in[1]` bounces 1,0,1 across successive ticks -> `btn_level[1]` stays 0 until 3 consecutive 1 samples; exactly one event.
- Buttons 0, 1 and 3 pressed in the same tick, `evt_ready` held 1 -> events issue in order 0, 1, 3. Then, with `rr_ptr`=0 after button 3 is served, a fresh press of button 0 issues next.
- `evt_ready`=0 held while button 2 is pressed, released and pressed again -> `evt_id` stays stable and `evt_ovf`=1. With the macro: after ready, the press issues first, then the release.
- Reset asserted during OFFER -> `evt_valid` is 0 within the same cycle; after release of reset, no stale events are offered.

Source files
------------

// File: rtl/btn_event_sched.sv
// btn_event_sched: shared-tick button debounce with round-robin valid/ready event delivery.
// Optional BTN_RELEASE_EVT_EN: falling edges also queue release events (evt_press=0).
module btn_event_sched #(
  parameter int N_BTN      = 4,
  parameter int TICK_DIV   = 100000,
  parameter int STABLE_CNT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn_in,
  output logic                     tick,
  output logic [N_BTN-1:0]         btn_level,
  output logic                     evt_valid,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic                     evt_press,
  input  logic                     evt_ready,
  output logic                     evt_ovf
);
  localparam int IW = $clog2(N_BTN);
  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = STABLE_CNT > 1 ? $clog2(STABLE_CNT) : 1;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t               state, nstate;
  logic [TW-1:0]        tcnt;
  logic [N_BTN-1:0]     s0, s1, lvl_q, press_pend, rise, sel_mask, press_clr, pend_any;
  logic [CW-1:0]        cnt [N_BTN];
  logic [IW-1:0]        rr_ptr, sel;
  logic                 hs, ovf_set;

  assign tick      = tcnt == TW'(TICK_DIV - 1);
  assign hs        = evt_valid & evt_ready;
  assign rise      = btn_level & ~lvl_q;
  assign sel_mask  = hs ? N_BTN'(1) << evt_id : '0;
  assign press_clr = evt_press ? sel_mask : '0;

`ifdef BTN_RELEASE_EVT_EN
  logic [N_BTN-1:0] rel_pend, fall, rel_clr;
  assign fall     = ~btn_level & lvl_q;
  assign rel_clr  = evt_press ? '0 : sel_mask;
  assign pend_any = press_pend | rel_pend;
  assign ovf_set  = |(rise & press_pend & ~press_clr) | |(fall & rel_pend & ~rel_clr);
  // release pending bits; a new edge wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rel_pend <= '0;
    else rel_pend <= (rel_pend & ~rel_clr) | fall;
`else
  assign pend_any  = press_pend;
  assign ovf_set   = |(rise & press_pend & ~press_clr);
  assign evt_press = 1'b1;
`endif

  // shared sample-tick divider
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= '0;
    else tcnt <= tick ? '0 : tcnt + 1'b1;

  // two-flop synchronizer, level filter, edge history, press pending and sticky overflow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s0         <= '0;
      s1         <= '0;
      btn_level  <= '0;
      lvl_q      <= '0;
      press_pend <= '0;
      evt_ovf    <= 1'b0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      s0         <= btn_in;
      s1         <= s0;
      lvl_q      <= btn_level;
      press_pend <= (press_pend & ~press_clr) | rise;
      evt_ovf    <= evt_ovf | ovf_set;
      for (int i = 0; i < N_BTN; i++)
        if (tick) begin
          if (s1[i] == btn_level[i]) cnt[i] <= '0;
          else if (cnt[i] == CW'(STABLE_CNT - 1)) begin
            btn_level[i] <= ~btn_level[i];
            cnt[i]       <= '0;
          end else cnt[i] <= cnt[i] + 1'b1;
        end
    end

  // round-robin pick: lowest offset from rr_ptr with any pending bit
  always_comb begin
    int idx;
    sel = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (pend_any[IW'(idx)]) sel = IW'(idx);
    end
  end

  // arbiter state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nstate;

  // arbiter next state
  always_comb begin
    nstate = state;
    if (state == IDLE && |pend_any) nstate = OFFER;
    else if (state == OFFER && evt_ready) nstate = IDLE;
  end

  // arbiter outputs
  always_comb evt_valid = state == OFFER;

  // latch the offered event in IDLE and advance the pointer past it on handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      evt_id <= '0;
      rr_ptr <= '0;
`ifdef BTN_RELEASE_EVT_EN
      evt_press <= 1'b0;
`endif
    end else begin
      if (state == IDLE && |pend_any) begin
        evt_id <= sel;
`ifdef BTN_RELEASE_EVT_EN
        evt_press <= press_pend[sel];
`endif
      end
      if (hs) rr_ptr <= evt_id == IW'(N_BTN - 1) ? '0 : evt_id + 1'b1;
    end
endmodule

// File: tb/tb_btn_event_sched.sv
// tb_btn_event_sched: directed checks of debounce, round-robin order, overflow and reset.
module tb_btn_event_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_in = '0;
  logic       evt_ready = 1'b0;
  logic       tick, evt_valid, evt_press, evt_ovf;
  logic [3:0] btn_level;
  logic [1:0] evt_id;
  logic [1:0] gid;
  logic       gpr;
  int         compared = 0;
  int         mismatched = 0;
  int         n, highs;

  btn_event_sched #(.N_BTN(4), .TICK_DIV(8), .STABLE_CNT(3)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .tick(tick), .btn_level(btn_level),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_press(evt_press),
    .evt_ready(evt_ready), .evt_ovf(evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int k = 0;
    while (tick !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    assert (k < 40) else begin
      mismatched++;
      $error("FAIL tick_timeout: observed no tick in %0d cycles", k);
    end
    step();
  endtask

  task automatic wait_evt(output logic [1:0] id, output logic pr);
    int k = 0;
    while (evt_valid !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    assert (k < 200) else begin
      mismatched++;
      $error("FAIL evt_timeout: observed no evt_valid in %0d cycles", k);
    end
    id = evt_id;
    pr = evt_press;
    step();
  endtask

  task automatic do_reset();
    btn_in = '0;
    evt_ready = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    step();
    step();
    chk("rst_tick", tick, 0);
    chk("rst_level", btn_level, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_id", evt_id, 0);
`ifdef BTN_RELEASE_EVT_EN
    chk("rst_press", evt_press, 0);
`else
    chk("rst_press", evt_press, 1);
`endif
    chk("rst_ovf", evt_ovf, 0);
    rst_n = 1'b1;
    wait_tick();
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("tick_period", n, 7);

    // single clean press of button 2
    wait_tick();
    btn_in[2] = 1'b1;
    wait_tick();
    wait_tick();
    chk("b2_level_before", btn_level, 4'b0000);
    wait_tick();
    chk("b2_level_after", btn_level, 4'b0100);
    chk("b2_valid_t0", evt_valid, 0);
    step();
    chk("b2_valid_t1", evt_valid, 0);
    step();
    chk("b2_valid_t2", evt_valid, 1);
    chk("b2_id", evt_id, 2);
    chk("b2_press", evt_press, 1);
    evt_ready = 1'b1;
    step();
    chk("b2_valid_after_hs", evt_valid, 0);
    evt_ready = 1'b0;

    // bouncing button 1: 1,0,1 then held
    wait_tick();
    btn_in[1] = 1'b1;
    wait_tick();
    btn_in[1] = 1'b0;
    wait_tick();
    btn_in[1] = 1'b1;
    wait_tick();
    wait_tick();
    chk("b1_bounce_hold", btn_level, 4'b0100);
    wait_tick();
    chk("b1_bounce_level", btn_level, 4'b0110);
    evt_ready = 1'b1;
    highs = 0;
    gid = '0;
    for (int i = 0; i < 40; i++) begin
      if (evt_valid) begin
        highs++;
        gid = evt_id;
      end
      step();
    end
    chk("b1_event_count", highs, 1);
    chk("b1_event_id", gid, 1);

    // simultaneous presses of 0,1,3 with ready held
    do_reset();
    evt_ready = 1'b1;
    wait_tick();
    btn_in = 4'b1011;
    wait_evt(gid, gpr);
    chk("rr_first", gid, 0);
    chk("rr_first_press", gpr, 1);
    chk("rr_gap", evt_valid, 0);
    wait_evt(gid, gpr);
    chk("rr_second", gid, 1);
    wait_evt(gid, gpr);
    chk("rr_third", gid, 3);
    btn_in = 4'b1010;
    for (int i = 0; i < 5; i++) wait_tick();
    btn_in = 4'b1111;
    wait_evt(gid, gpr);
`ifdef BTN_RELEASE_EVT_EN
    chk("rr_fresh_first", gid, 2);
`else
    chk("rr_fresh_first", gid, 0);
`endif
    chk("rr_fresh_press", gpr, 1);
    wait_evt(gid, gpr);
`ifdef BTN_RELEASE_EVT_EN
    chk("rr_fresh_second", gid, 0);
`else
    chk("rr_fresh_second", gid, 2);
`endif

    // stalled consumer: press, release, press on button 2
    do_reset();
    wait_tick();
    btn_in = 4'b0100;
    for (int i = 0; i < 3; i++) wait_tick();
    step();
    step();
    chk("ovf_offer_valid", evt_valid, 1);
    chk("ovf_offer_id", evt_id, 2);
    chk("ovf_none_yet", evt_ovf, 0);
    btn_in = 4'b0000;
    for (int i = 0; i < 4; i++) wait_tick();
    chk("ovf_released", btn_level, 4'b0000);
    btn_in = 4'b0100;
    for (int i = 0; i < 4; i++) wait_tick();
    step();
    step();
    chk("ovf_set", evt_ovf, 1);
    chk("ovf_hold_valid", evt_valid, 1);
    chk("ovf_hold_id", evt_id, 2);
    chk("ovf_hold_press", evt_press, 1);
    evt_ready = 1'b1;
    wait_evt(gid, gpr);
    chk("ovf_drain_id", gid, 2);
    chk("ovf_drain_press", gpr, 1);
`ifdef BTN_RELEASE_EVT_EN
    wait_evt(gid, gpr);
    chk("ovf_rel_id", gid, 2);
    chk("ovf_rel_press", gpr, 0);
`endif
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      if (evt_valid) highs++;
      step();
    end
    chk("ovf_no_more", highs, 0);
    chk("ovf_sticky", evt_ovf, 1);

    // reset during an offer
    do_reset();
    wait_tick();
    btn_in = 4'b0010;
    for (int i = 0; i < 3; i++) wait_tick();
    step();
    step();
    chk("rst_mid_offer_valid", evt_valid, 1);
    chk("rst_mid_offer_id", evt_id, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", evt_valid, 0);
    chk("rst_async_level", btn_level, 0);
    btn_in = 4'b0000;
    step();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      if (evt_valid) highs++;
      step();
    end
    chk("rst_no_stale", highs, 0);
    chk("rst_ovf_clear", evt_ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
